// File: rtl/melody_sequencer_if.sv
// Note-ROM bus between the melody sequencer and its synchronous note ROM.
//   rom_addr : ROM word address, driven by the sequencer (master)
//   rom_data : {half_period[DIV_W-1:0], duration[3:0]}, valid one clock
//              after rom_addr changes, driven by the ROM (slave)
interface melody_sequencer_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DIV_W  = 17
);
  logic [ADDR_W-1:0] rom_addr;
  logic [DIV_W+3:0]  rom_data;

  modport master (output rom_addr, input  rom_data);
  modport slave  (input  rom_addr, output rom_data);
endinterface

// File: rtl/melody_sequencer.sv
// Melody sequencer: walks an external synchronous note ROM and plays each
// note as a square wave for its duration in beat ticks.
// Ports:
//   clk_in    : system clock
//   rst_n     : asynchronous active-low reset
//   start     : pulse, begin from idle or resume from pause
//   pause     : pulse, freeze playback (only honoured while playing)
//   stop      : pulse, abort to idle without a done pulse
//   beat_tick : pulse, beat enable from the clock divider
//   rom       : note ROM bus (master side)
//   tone_out  : square-wave audio output
//   busy      : high whenever the sequencer is not idle
//   done      : one-cycle pulse at the natural end of the song
module melody_sequencer #(
  parameter int unsigned NOTE_NUM = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DIV_W    = 17,
  parameter bit          LOOP     = 1'b0
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 stop,
  input  logic                 beat_tick,
  melody_sequencer_if.master   rom,
  output logic                 tone_out,
  output logic                 busy,
  output logic                 done
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_PLAY  = 3'd3;
  localparam logic [2:0] ST_PAUSE = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NOTE_NUM - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DIV_W-1:0]  hp_q,    hp_d;
  logic [DIV_W-1:0]  cnt_q,   cnt_d;
  logic [3:0]        beats_q, beats_d;
  logic              tone_q,  tone_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic              song_end;

  logic [DIV_W-1:0]  rom_hp;
  logic [3:0]        rom_dur;

  assign rom_hp  = rom.rom_data[DIV_W+3:4];
  assign rom_dur = rom.rom_data[3:0];

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    hp_d     = hp_q;
    cnt_d    = cnt_q;
    beats_d  = beats_q;
    tone_d   = tone_q;
    done_d   = 1'b0;
    song_end = 1'b0;

    case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        tone_d = 1'b0;
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        tone_d  = 1'b0;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        tone_d = 1'b0;
        if (rom_dur == 4'd0) begin
          song_end = 1'b1;
        end else begin
          hp_d    = rom_hp;
          beats_d = rom_dur;
          cnt_d   = '0;
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (pause) begin
          // Pause wins over a coincident beat tick, which is dropped.
          state_d = ST_PAUSE;
          tone_d  = 1'b0;
        end else begin
          if (hp_q != '0) begin
            if (cnt_q == hp_q - DIV_W'(1)) begin
              cnt_d  = '0;
              tone_d = ~tone_q;
            end else begin
              cnt_d = cnt_q + DIV_W'(1);
            end
          end else begin
            tone_d = 1'b0;
          end
          if (beat_tick) begin
            if (beats_q == 4'd1) begin
              tone_d = 1'b0;
              if (addr_q == LAST_ADDR) begin
                song_end = 1'b1;
              end else begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = ST_FETCH;
              end
            end else begin
              beats_d = beats_q - 4'd1;
            end
          end
        end
      end
      ST_PAUSE: begin
        // Counter stays frozen; the waveform restarts low on resume.
        tone_d = 1'b0;
        if (start && !pause) state_d = ST_PLAY;
      end
      default: begin
        state_d = ST_IDLE;
        addr_d  = '0;
        tone_d  = 1'b0;
      end
    endcase

    if (song_end) begin
      done_d  = 1'b1;
      addr_d  = '0;
      tone_d  = 1'b0;
      state_d = LOOP ? ST_FETCH : ST_IDLE;
    end

    if (stop) begin
      state_d = ST_IDLE;
      addr_d  = '0;
      tone_d  = 1'b0;
      done_d  = 1'b0;
      cnt_d   = '0;
      beats_d = '0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      hp_q    <= '0;
      cnt_q   <= '0;
      beats_q <= '0;
      tone_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hp_q    <= hp_d;
      cnt_q   <= cnt_d;
      beats_q <= beats_d;
      tone_q  <= tone_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rom.rom_addr = addr_q;
  assign tone_out     = tone_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Testbench for melody_sequencer: a table of cycle vectors, hand-written
// loop/stop/reset sequences, and randomized play checked against a
// note-level reference model.
module tb_melody_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 32 notes, no loop. DUT B: 4 notes, looping.
  logic sA = 0, pA = 0, spA = 0, btA = 0;
  logic toneA, busyA, doneA;
  logic sB = 0, pB = 0, spB = 0, btB = 0;
  logic toneB, busyB, doneB;

  melody_sequencer_if #(.ADDR_W(5), .DIV_W(17)) ifA ();
  melody_sequencer_if #(.ADDR_W(2), .DIV_W(17)) ifB ();

  melody_sequencer #(.NOTE_NUM(32), .ADDR_W(5), .DIV_W(17), .LOOP(1'b0)) dutA (
    .clk_in(clk), .rst_n(rst_n), .start(sA), .pause(pA), .stop(spA),
    .beat_tick(btA), .rom(ifA), .tone_out(toneA), .busy(busyA), .done(doneA));

  melody_sequencer #(.NOTE_NUM(4), .ADDR_W(2), .DIV_W(17), .LOOP(1'b1)) dutB (
    .clk_in(clk), .rst_n(rst_n), .start(sB), .pause(pB), .stop(spB),
    .beat_tick(btB), .rom(ifB), .tone_out(toneB), .busy(busyB), .done(doneB));

  logic [20:0] memA [32];
  logic [20:0] memB [4];

  always @(posedge clk) begin
    ifA.rom_data <= memA[ifA.rom_addr];
    ifB.rom_data <= memB[ifB.rom_addr];
  end

  int nchecks = 0;
  int nerr = 0;

  task automatic chk(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Loop monitor for DUT B
  bit mon_en = 0;
  int dcntB = 0;
  bit bdropB = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (doneB) dcntB++;
      if (!busyB) bdropB = 1;
    end
  end

  // Reference model: a note is idle / in its 2-cycle gap / playing / paused.
  // While playing, the number of half-period boundaries crossed since the
  // last (re)start decides the tone level.
  int m_mode;     // 0 idle, 1 gap, 2 play, 3 paused
  int m_gap, m_idx, m_beats, m_elapsed, m_base, m_hp;
  bit m_done;

  task automatic model_reset();
    m_mode = 0; m_gap = 0; m_idx = 0; m_beats = 0;
    m_elapsed = 0; m_base = 0; m_hp = 0; m_done = 0;
  endtask

  task automatic model_end_song();
    m_done = 1; m_idx = 0; m_mode = 0;
  endtask

  task automatic model_step(input bit st, input bit pa, input bit sp, input bit bt);
    int dur;
    m_done = 0;
    if (sp) begin
      m_mode = 0; m_idx = 0;
      return;
    end
    case (m_mode)
      0: if (st) begin m_mode = 1; m_gap = 2; end
      1: begin
        if (m_gap == 2) m_gap = 1;
        else begin
          dur = int'(memA[m_idx][3:0]);
          if (dur == 0) model_end_song();
          else begin
            m_hp = int'(memA[m_idx][20:4]);
            m_beats = dur; m_elapsed = 0; m_base = 0; m_mode = 2;
          end
        end
      end
      2: begin
        if (pa) m_mode = 3;
        else if (bt && m_beats == 1) begin
          if (m_idx == 31) model_end_song();
          else begin m_idx++; m_mode = 1; m_gap = 2; end
        end else begin
          if (bt) m_beats--;
          m_elapsed++;
        end
      end
      default: if (st && !pa) begin
        m_mode = 2;
        m_base = (m_hp == 0) ? 0 : m_elapsed / m_hp;
      end
    endcase
  endtask

  function automatic int model_tone();
    if (m_mode == 2 && m_hp != 0) return ((m_elapsed / m_hp) - m_base) % 2;
    return 0;
  endfunction

  typedef struct {
    bit st, pa, sp, bt;
    bit e_busy;
    int e_addr;
    bit e_tone;
    bit e_done;
  } vec_t;

  vec_t tbl[23];

  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    // ROM A for the table: {hp=2,dur=3}, {rest,dur=1}, end
    for (int i = 0; i < 32; i++) memA[i] = '0;
    memA[0] = {17'd2, 4'd3};
    memA[1] = {17'd0, 4'd1};
    memA[2] = {17'd0, 4'd0};
    for (int i = 0; i < 4; i++) memB[i] = {17'd1, 4'd1};

    //           st pa sp bt  busy addr tone done
    tbl[0]  = '{1, 0, 0, 0,  1, 0, 0, 0};  // -> FETCH
    tbl[1]  = '{0, 0, 0, 0,  1, 0, 0, 0};  // -> LOAD
    tbl[2]  = '{0, 0, 0, 0,  1, 0, 0, 0};  // -> PLAY, low
    tbl[3]  = '{0, 0, 0, 0,  1, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0,  1, 0, 1, 0};  // first toggle after 2 cycles
    tbl[5]  = '{0, 0, 0, 1,  1, 0, 1, 0};  // beats 3 -> 2
    tbl[6]  = '{0, 1, 0, 1,  1, 0, 0, 0};  // pause; coincident tick dropped
    tbl[7]  = '{0, 0, 0, 1,  1, 0, 0, 0};  // ticks ignored while paused
    tbl[8]  = '{0, 0, 0, 1,  1, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 1,  1, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 1,  1, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 1,  1, 0, 0, 0};
    tbl[12] = '{1, 0, 0, 0,  1, 0, 0, 0};  // resume, tone restarts low
    tbl[13] = '{0, 0, 0, 0,  1, 0, 1, 0};  // frozen counter continues
    tbl[14] = '{0, 0, 0, 1,  1, 0, 1, 0};  // beats 2 -> 1
    tbl[15] = '{0, 0, 0, 1,  1, 1, 0, 0};  // note ends
    tbl[16] = '{0, 0, 0, 0,  1, 1, 0, 0};
    tbl[17] = '{0, 0, 0, 0,  1, 1, 0, 0};  // rest note plays
    tbl[18] = '{1, 0, 0, 0,  1, 1, 0, 0};  // start ignored while playing
    tbl[19] = '{0, 0, 0, 1,  1, 2, 0, 0};
    tbl[20] = '{0, 0, 0, 0,  1, 2, 0, 0};
    tbl[21] = '{0, 0, 0, 0,  0, 0, 0, 1};  // duration 0 -> done
    tbl[22] = '{0, 0, 0, 0,  0, 0, 0, 0};  // done lasts one cycle

    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busyA, 0);
    chk("reset_addr", int'(ifA.rom_addr), 0);
    chk("reset_tone", toneA, 0);
    chk("reset_done", doneA, 0);
    rst_n = 1;

    // Table vectors on DUT A
    for (int i = 0; i < 23; i++) begin
      sA = tbl[i].st; pA = tbl[i].pa; spA = tbl[i].sp; btA = tbl[i].bt;
      @(posedge clk);
      #1;
      sA = 0; pA = 0; spA = 0; btA = 0;
      chk($sformatf("tbl%0d_busy", i), busyA, tbl[i].e_busy);
      chk($sformatf("tbl%0d_addr", i), int'(ifA.rom_addr), tbl[i].e_addr);
      chk($sformatf("tbl%0d_tone", i), toneA, tbl[i].e_tone);
      chk($sformatf("tbl%0d_done", i), doneA, tbl[i].e_done);
    end

    // DUT B: looping song, 9 beat ticks
    sB = 1; @(posedge clk); #1 sB = 0;
    mon_en = 1;
    for (int k = 0; k < 9; k++) begin
      repeat (9) @(posedge clk);
      #1;
      chk($sformatf("loop_addr%0d", k), int'(ifB.rom_addr), k % 4);
      btB = 1; @(posedge clk); #1 btB = 0;
    end
    repeat (4) @(posedge clk);
    #1;
    mon_en = 0;
    chk("loop_done_count", dcntB, 2);
    chk("loop_busy_dropped", int'(bdropB), 0);

    // Advance B to address 3, then stop+start together while playing
    for (int k = 0; k < 2; k++) begin
      btB = 1; @(posedge clk); #1 btB = 0;
      repeat (4) @(posedge clk);
      #1;
    end
    chk("pre_stop_addr", int'(ifB.rom_addr), 3);
    dcntB = 0;
    mon_en = 1;
    sB = 1; spB = 1; @(posedge clk); #1 sB = 0; spB = 0;
    chk("stop_busy", busyB, 0);
    chk("stop_addr", int'(ifB.rom_addr), 0);
    chk("stop_tone", toneB, 0);
    repeat (5) @(posedge clk);
    #1;
    mon_en = 0;
    chk("stop_no_done", dcntB, 0);
    chk("stop_stays_idle", busyB, 0);

    // Randomized play on DUT A against the reference model
    do_reset();
    for (int i = 0; i < 32; i++) begin
      if ($urandom_range(0, 7) == 0) memA[i] = {17'($urandom_range(0, 5)), 4'd0};
      else memA[i] = {17'($urandom_range(0, 5)), 4'($urandom_range(1, 3))};
    end
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      sA  = (r < 6);
      pA  = (r >= 6 && r < 9);
      spA = (r == 9);
      btA = ($urandom_range(0, 3) == 0);
      @(posedge clk);
      model_step(sA, pA, spA, btA);
      #1;
      chk("rnd_busy", busyA, (m_mode != 0) ? 1 : 0);
      chk("rnd_addr", int'(ifA.rom_addr), m_idx);
      chk("rnd_tone", toneA, model_tone());
      chk("rnd_done", doneA, int'(m_done));
    end
    sA = 0; pA = 0; spA = 0; btA = 0;

    // Asynchronous reset mid-play on DUT B
    sB = 1; @(posedge clk); #1 sB = 0;
    repeat (4) @(posedge clk);
    #1 btB = 1; @(posedge clk); #1 btB = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_busy", busyB, 1);
    chk("pre_rst_addr", int'(ifB.rom_addr), 1);
    #2 rst_n = 0;
    #1;
    chk("arst_busy", busyB, 0);
    chk("arst_addr", int'(ifB.rom_addr), 0);
    chk("arst_tone", toneB, 0);
    chk("arst_done", doneB, 0);
    chk("arst_busyA", busyA, 0);
    #20 rst_n = 1;

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
